// File: rtl/branch_cond_unit.sv
// branch_cond_unit: architectural condition-code register, conditional-branch
// resolution with same-cycle flag bypass, a one-entry registered decision
// buffer, and saturating branch statistics counters.
module branch_cond_unit #(
    parameter int DISP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        szcv_in,
    input  logic              flag_we,
    output logic [3:0]        flags,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [15:0]       br_pc,
    input  logic [DISP_W-1:0] br_disp,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [15:0]       res_target,
    input  logic              flush,
    output logic [CNT_W-1:0]  cnt_branches,
    output logic [CNT_W-1:0]  cnt_taken
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        eff_s;
    logic        eff_z;
    logic        eff_v;
    logic        cond_taken;
    logic [15:0] disp_sext;
    logic [15:0] next_target;

    // Reset and flush both block acceptance so nothing slips into a buffer
    // that is about to be cleared.
    assign res_valid = (state == FULL);
    assign br_ready  = !rst && !flush && (!res_valid || res_ready);
    assign accept    = br_valid && br_ready;

    // Resolve the condition against the bypassed flags and form the next PC.
    always_comb begin
        eff_s      = flag_we ? szcv_in[3] : flags[3];
        eff_z      = flag_we ? szcv_in[2] : flags[2];
        eff_v      = flag_we ? szcv_in[0] : flags[0];
        cond_taken = 1'b0;
        case (br_cond)
            3'b000:  cond_taken = eff_z;
            3'b001:  cond_taken = eff_s ^ eff_v;
            3'b010:  cond_taken = eff_z | (eff_s ^ eff_v);
            3'b011:  cond_taken = !eff_z;
            3'b100:  cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
        disp_sext   = 16'($signed(br_disp));
        next_target = br_pc + 16'd1 + (cond_taken ? disp_sext : 16'd0);
    end

    // Condition-code register, written by the execute stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (flag_we) begin
            flags <= szcv_in;
        end
    end

    // Decision buffer occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything; an accept refills even while draining.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = FULL;
        end else if (res_valid && res_ready) begin
            state_next = EMPTY;
        end
    end

    // Decision payload, loaded only on accept so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_taken  <= 1'b0;
            res_target <= 16'h0000;
        end else if (accept) begin
            res_taken  <= cond_taken;
            res_target <= next_target;
        end
    end

    // Saturating statistics: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches <= '0;
            cnt_taken    <= '0;
        end else if (accept) begin
            if (cnt_branches != {CNT_W{1'b1}}) begin
                cnt_branches <= cnt_branches + CNT_W'(1);
            end
            if (cond_taken && (cnt_taken != {CNT_W{1'b1}})) begin
                cnt_taken <= cnt_taken + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: a behavioural reference model is
// compared every cycle against two instances (16-bit and 2-bit counters)
// driven with identical directed vectors, plus hand-computed literal checks.
module tb_branch_cond_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  szcv_in;
    logic        flag_we;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [7:0]  br_disp;
    logic        res_ready;
    logic        flush;

    logic [3:0]  flags_a,   flags_b;
    logic        ready_a,   ready_b;
    logic        valid_a,   valid_b;
    logic        taken_a,   taken_b;
    logic [15:0] target_a,  target_b;
    logic [15:0] cbr_a,     ctk_a;
    logic [1:0]  cbr_b,     ctk_b;

    int total;
    int bad;

    // Reference model state
    logic [3:0]  m_flags;
    bit          m_valid;
    bit          m_taken;
    int          m_target;
    int          m_cbr_a, m_ctk_a, m_cbr_b, m_ctk_b;

    branch_cond_unit #(.DISP_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .szcv_in(szcv_in), .flag_we(flag_we),
        .flags(flags_a), .br_valid(br_valid), .br_ready(ready_a),
        .br_cond(br_cond), .br_pc(br_pc), .br_disp(br_disp),
        .res_valid(valid_a), .res_ready(res_ready), .res_taken(taken_a),
        .res_target(target_a), .flush(flush),
        .cnt_branches(cbr_a), .cnt_taken(ctk_a)
    );

    branch_cond_unit #(.DISP_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .szcv_in(szcv_in), .flag_we(flag_we),
        .flags(flags_b), .br_valid(br_valid), .br_ready(ready_b),
        .br_cond(br_cond), .br_pc(br_pc), .br_disp(br_disp),
        .res_valid(valid_b), .res_ready(res_ready), .res_taken(taken_b),
        .res_target(target_b), .flush(flush),
        .cnt_branches(cbr_b), .cnt_taken(ctk_b)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit modelTaken(input logic [2:0] c, input logic [3:0] f);
        bit s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            3'd4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int satInc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic bit modelReady();
        return !rst && !flush && (!m_valid || res_ready);
    endfunction

    // Reference model: advances on each rising edge from the inputs held there
    always @(posedge clk) begin
        bit          acc;
        bit          tk;
        logic [3:0]  eff;
        int          disp;
        if (rst) begin
            m_flags  = 4'b0000;
            m_valid  = 1'b0;
            m_taken  = 1'b0;
            m_target = 0;
            m_cbr_a  = 0;
            m_ctk_a  = 0;
            m_cbr_b  = 0;
            m_ctk_b  = 0;
        end else begin
            acc  = br_valid && modelReady();
            eff  = flag_we ? szcv_in : m_flags;
            tk   = modelTaken(br_cond, eff);
            disp = (int'(br_disp) >= 128) ? int'(br_disp) - 256 : int'(br_disp);
            if (acc) begin
                m_cbr_a = satInc(m_cbr_a, 65535);
                m_cbr_b = satInc(m_cbr_b, 3);
                if (tk) begin
                    m_ctk_a = satInc(m_ctk_a, 65535);
                    m_ctk_b = satInc(m_ctk_b, 3);
                end
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid  = 1'b1;
                m_taken  = tk;
                m_target = (int'(br_pc) + 1 + (tk ? disp : 0)) & 32'h0000FFFF;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
            if (flag_we) m_flags = szcv_in;
        end
    end

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        checkOutput("flags_a",  32'(flags_a),  32'(m_flags));
        checkOutput("flags_b",  32'(flags_b),  32'(m_flags));
        checkOutput("valid_a",  32'(valid_a),  32'(m_valid));
        checkOutput("valid_b",  32'(valid_b),  32'(m_valid));
        checkOutput("ready_a",  32'(ready_a),  32'(modelReady()));
        checkOutput("ready_b",  32'(ready_b),  32'(modelReady()));
        if (m_valid) begin
            checkOutput("taken_a",  32'(taken_a),  32'(m_taken));
            checkOutput("target_a", 32'(target_a), 32'(m_target));
            checkOutput("taken_b",  32'(taken_b),  32'(m_taken));
            checkOutput("target_b", 32'(target_b), 32'(m_target));
        end
        checkOutput("cnt_br_a", 32'(cbr_a), 32'(m_cbr_a));
        checkOutput("cnt_tk_a", 32'(ctk_a), 32'(m_ctk_a));
        checkOutput("cnt_br_b", 32'(cbr_b), 32'(m_cbr_b));
        checkOutput("cnt_tk_b", 32'(ctk_b), 32'(m_ctk_b));
    end

    // Drive one cycle of inputs, then return 1 time unit after the next rising edge
    task automatic applyStimulus(input logic r, input logic fwe, input logic [3:0] sz,
                                 input logic bv, input logic [2:0] c, input logic [15:0] pc,
                                 input logic [7:0] d, input logic rr, input logic fl);
        rst       = r;
        flag_we   = fwe;
        szcv_in   = sz;
        br_valid  = bv;
        br_cond   = c;
        br_pc     = pc;
        br_disp   = d;
        res_ready = rr;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held two cycles while flag_we and br_valid are asserted
        applyStimulus(1, 1, 4'hF, 1, 3'd4, 16'h0000, 8'h00, 1, 0);
        applyStimulus(1, 1, 4'hF, 1, 3'd4, 16'h0000, 8'h00, 1, 0);
        checkOutput("rst_flags",  32'(flags_a),  32'h0);
        checkOutput("rst_valid",  32'(valid_a),  32'h0);
        checkOutput("rst_taken",  32'(taken_a),  32'h0);
        checkOutput("rst_target", 32'(target_a), 32'h0);
        checkOutput("rst_cnt_br", 32'(cbr_a),    32'h0);
        checkOutput("rst_cnt_tk", 32'(ctk_a),    32'h0);
        applyStimulus(0, 0, 4'h0, 0, 3'd0, 16'h0000, 8'h00, 1, 0);
        checkOutput("ready_after_rst", 32'(ready_a), 32'h1);

        // Bypass: Z written and used in the same cycle
        applyStimulus(0, 1, 4'b0100, 1, 3'd0, 16'h0010, 8'hFE, 1, 0);
        checkOutput("bypass_valid",  32'(valid_a),  32'h1);
        checkOutput("bypass_taken",  32'(taken_a),  32'h1);
        checkOutput("bypass_target", 32'(target_a), 32'h000F);

        // Signed conditions
        applyStimulus(0, 1, 4'b1000, 0, 3'd0, 16'h0000, 8'h00, 1, 0);
        applyStimulus(0, 0, 4'b0000, 1, 3'd1, 16'h0100, 8'h05, 1, 0);
        checkOutput("blt_sv10_taken",  32'(taken_a),  32'h1);
        checkOutput("blt_sv10_target", 32'(target_a), 32'h0106);
        applyStimulus(0, 1, 4'b1001, 0, 3'd0, 16'h0000, 8'h00, 1, 0);
        applyStimulus(0, 0, 4'b0000, 1, 3'd1, 16'h0200, 8'h10, 1, 0);
        checkOutput("blt_sv11_taken",  32'(taken_a),  32'h0);
        checkOutput("blt_sv11_target", 32'(target_a), 32'h0201);
        applyStimulus(0, 1, 4'b0100, 1, 3'd2, 16'h0300, 8'h80, 1, 0);
        checkOutput("ble_z_taken",  32'(taken_a),  32'h1);
        checkOutput("ble_z_target", 32'(target_a), 32'h0281);

        // Wrap-around, reserved code, BNE with Z set
        applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'hFFFF, 8'h00, 1, 0);
        checkOutput("wrap_taken",  32'(taken_a),  32'h1);
        checkOutput("wrap_target", 32'(target_a), 32'h0000);
        applyStimulus(0, 0, 4'b0000, 1, 3'd6, 16'h1234, 8'h7F, 1, 0);
        checkOutput("rsvd_taken",  32'(taken_a),  32'h0);
        checkOutput("rsvd_target", 32'(target_a), 32'h1235);
        applyStimulus(0, 0, 4'b0000, 1, 3'd3, 16'h2000, 8'h40, 1, 0);
        checkOutput("bne_z_taken",  32'(taken_a),  32'h0);
        checkOutput("bne_z_target", 32'(target_a), 32'h2001);

        // Backpressure: three stalled cycles, outputs must hold
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'h0400, 8'h01, 0, 0);
            checkOutput("stall_ready",  32'(ready_a),  32'h0);
            checkOutput("stall_target", 32'(target_a), 32'h2001);
        end
        applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'h0400, 8'h01, 1, 0);
        checkOutput("refill_valid",  32'(valid_a),  32'h1);
        checkOutput("refill_target", 32'(target_a), 32'h0402);
        applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'h0500, 8'hFF, 1, 0);
        checkOutput("stream_target", 32'(target_a), 32'h0500);

        // Flush while full: valid drops, nothing accepted
        applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'h0700, 8'h00, 0, 1);
        checkOutput("flush_valid", 32'(valid_a), 32'h0);
        checkOutput("flush_cnt",   32'(cbr_a),   32'd9);

        // Saturation: five more taken branches
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'h0600 + 16'(i), 8'h02, 1, 0);
        end
        checkOutput("sat_tk_b", 32'(ctk_b), 32'd3);
        checkOutput("sat_br_b", 32'(cbr_b), 32'd3);
        checkOutput("cnt_br_a", 32'(cbr_a), 32'd14);
        checkOutput("cnt_tk_a", 32'(ctk_a), 32'd11);

        // Reset mid-operation drops the held decision and beats flag_we
        applyStimulus(0, 0, 4'b0000, 1, 3'd4, 16'h0800, 8'h00, 0, 0);
        applyStimulus(1, 1, 4'hF, 1, 3'd4, 16'h0900, 8'h00, 0, 1);
        checkOutput("midrst_valid", 32'(valid_a), 32'h0);
        checkOutput("midrst_flags", 32'(flags_a), 32'h0);
        checkOutput("midrst_cnt",   32'(cbr_a),   32'h0);
        applyStimulus(0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1, 0);
        applyStimulus(0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer of the ALU's `szcv` flag output. Holds the architectural condition-code register, resolves conditional-branch requests against it, and returns a registered taken/not-taken decision with a 16-bit target PC. Sits between the execute stage (flags writer) and PC-update logic (decision reader). Also keeps saturating branch statistics counters.

## Interface
- `DISP_W`, default 8: branch displacement width, sign-extended to 16 bits.
- `CNT_W`, default 16: statistics counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `szcv_in` in 4: flags from the ALU, ordered [3]=S, [2]=Z, [1]=C, [0]=V.
- `flag_we` in 1: write `szcv_in` into the flag register this cycle.
- `flags` out 4: current flag register contents.
- `br_valid` in 1: branch request valid.
- `br_ready` out 1: unit can accept a request.
- `br_cond` in 3: condition code; see Operation.
- `br_pc` in 16: PC of the branch instruction.
- `br_disp` in `DISP_W`: signed displacement.
- `res_valid` out 1: decision valid.
- `res_ready` in 1: downstream accepts the decision.
- `res_taken` out 1: branch taken.
- `res_target` out 16: next PC.
- `flush` in 1: discard the held decision.
- `cnt_branches` out `CNT_W`: accepted requests, saturating.
- `cnt_taken` out `CNT_W`: taken decisions, saturating.

## Operation
**Flag register**
- Loaded with `szcv_in` on any cycle with `flag_we`=1; otherwise holds its value.
- Reset value is 4'b0000.

**Condition codes** (`eff` = effective flags)
- 000 BE: taken if Z.
- 001 BLT: taken if S^V.
- 010 BLE: taken if Z | (S^V).
- 011 BNE: taken if !Z.
- 100 B: always taken.
- 101–111: never taken; `res_target` = `br_pc`+1.

**Flag bypass**
- If `flag_we`=1 in the same cycle a request is accepted, `eff` = `szcv_in`.
- Otherwise `eff` = `flags`.
- C is stored but used by no condition.

**Target computation**
- Taken: `br_pc` + 1 + sext(`br_disp`), modulo 2^16. Wrap-around is silent, e.g. 16'hFFFF + 1 + 0 = 16'h0000.
- Not taken: `br_pc` + 1, modulo 2^16.

**Output register** (one entry, states EMPTY/FULL)
- `br_ready` = !`res_valid` | `res_ready`, combinational.
- Accept: `br_valid` & `br_ready` loads `res_taken` and `res_target` and sets `res_valid`.
- Drain: `res_valid` & `res_ready` with no accept clears `res_valid`.
- Simultaneous drain and accept: the new result replaces the old; `res_valid` stays 1.
- While `res_valid` & !`res_ready`, outputs hold stable.

**Flush**
- Clears `res_valid` at the next edge, and `br_ready` is forced to 0 that cycle, so no request is accepted while `flush`=1.
- The flag register and counters are unaffected.

**Counters**
- `cnt_branches` increments on every accept; `cnt_taken` increments on every accept whose decision is taken.
- Both saturate at all-ones.
- Flush does not decrement either counter.

## Timing
- Decision latency: 1 cycle from the accept edge to `res_valid`=1.
- Throughput: 1 request/cycle while `res_ready`=1.
- Flag write-to-use latency: 0 cycles via the bypass.
- Values after `rst`:
  - `flags`=0
  - `res_valid`=0
  - `res_taken`=0
  - `res_target`=0
  - both counters 0
  - `br_ready`=1 once `rst` deasserts
- `rst` mid-operation drops any held decision; no request is accepted in a cycle with `rst`=1.
- `rst` overrides `flush` and `flag_we`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `flag_we`=1 and `br_valid`=1 -> `flags`=0, `res_valid`=0, counters 0 after deassert.
- **Bypass:** `flags`=0000, then in the same cycle `flag_we`=1 with `szcv_in`=0100 and BE with `br_pc`=16'h0010, `br_disp`=8'hFE -> next cycle `res_taken`=1, `res_target`=16'h000F.
- **Signed conditions:** load S=1,V=0 and issue BLT -> taken. Load S=1,V=1 and issue BLT -> not taken, target `br_pc`+1. BLE with Z=1 -> taken.
- **Wrap and reserved codes:** B with `br_pc`=16'hFFFF, `br_disp`=8'h00 -> taken, target 16'h0000. `br_cond`=110 -> not taken.
- **Backpressure:** hold `res_ready`=0 for 3 cycles with `br_valid`=1 -> `br_ready`=0 and outputs stable. Raise `res_ready` -> drain and accept in the same cycle, 1 result per cycle afterwards.
- **Flush and saturation:** `flush` while FULL -> `res_valid`=0 next cycle and counters unchanged. With `CNT_W`=2, 5 taken branches -> `cnt_taken`=3.
